// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register tags for rename/dispatch.
//   Dispatch pops tags from the head. Retire pushes old destination tags at
//   the tail. A branch mispredict rewinds the head to the index checkpointed
//   for that branch. This returns every wrong-path tag in a single cycle.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset; overrides every other input
//   alloc_en_i      dispatch consumes fl_tag_o this cycle
//   retire_en_i     push retire_tag_i at the tail
//   retire_tag_i    old destination tag from the ROB
//   br_recovery_i   mispredict recovery; drops this cycle's alloc
//   recover_head_i  checkpointed head index to restore
//   fl_tag_o        tag stored at the head
//   fl_cur_head_o   current head index (checkpointed by the ROB)
//   fl_empty_o      no free tag available; dispatch must stall
//   fl_err_o        sticky: a retire arrived while the list was full
// -----------------------------------------------------------------------------
module free_list #(
  parameter int PRF_IDX_W = 6,
  parameter int FL_DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en_i,
  input  logic                 retire_en_i,
  input  logic [PRF_IDX_W-1:0] retire_tag_i,
  input  logic                 br_recovery_i,
  input  logic [PRF_IDX_W-2:0] recover_head_i,
  output logic [PRF_IDX_W-1:0] fl_tag_o,
  output logic [PRF_IDX_W-2:0] fl_cur_head_o,
  output logic                 fl_empty_o,
  output logic                 fl_err_o
);

  localparam int PTR_W = PRF_IDX_W - 1;
  localparam logic [PRF_IDX_W-1:0] FULL_COUNT = PRF_IDX_W'(FL_DEPTH);

  // Every slot has a reset value, so the storage is a register array and
  // not a block RAM.
  logic [PRF_IDX_W-1:0] mem [FL_DEPTH];

  logic [PTR_W-1:0]     head_reg;
  logic [PTR_W-1:0]     head_next;
  logic [PTR_W-1:0]     tail_reg;
  logic [PTR_W-1:0]     tail_next;
  logic [PRF_IDX_W-1:0] count_reg;
  logic [PRF_IDX_W-1:0] count_next;
  logic                 err_reg;

  logic                 empty;
  logic                 full;
  logic                 alloc_ok;
  logic                 retire_ok;
  logic                 overflow;
  logic [PTR_W-1:0]     rollback_dist;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  // A recovery cycle drops the alloc. The dispatched instruction is on the
  // wrong path.
  assign alloc_ok  = alloc_en_i & ~empty & ~br_recovery_i;
  assign retire_ok = retire_en_i & ~full;
  assign overflow  = retire_en_i & full;

  // The pointer arithmetic wraps modulo FL_DEPTH. This gives the number of
  // tags allocated since the checkpoint. At most FL_DEPTH-1 allocations can
  // follow a branch in flight, so this value is never ambiguous.
  assign rollback_dist = head_reg - recover_head_i;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;

    if (br_recovery_i) begin
      head_next  = recover_head_i;
      count_next = count_reg + PRF_IDX_W'(rollback_dist) + PRF_IDX_W'(retire_ok);
    end else begin
      if (alloc_ok) begin
        head_next = head_reg + PTR_W'(1);
      end
      case ({alloc_ok, retire_ok})
        2'b10:   count_next = count_reg - PRF_IDX_W'(1);
        2'b01:   count_next = count_reg + PRF_IDX_W'(1);
        default: count_next = count_reg;
      endcase
    end

    if (retire_ok) begin
      tail_next = tail_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= FULL_COUNT;
      err_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      if (overflow) begin
        err_reg <= 1'b1;
      end
    end
  end

  // One register per slot. After reset the list holds tags
  // FL_DEPTH..2*FL_DEPTH-1. Tags 0..FL_DEPTH-1 back the architectural map.
  // Recovery never writes here: rolled-back tags are still in their slots.
  generate
    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          mem[gi] <= PRF_IDX_W'(FL_DEPTH + gi);
        end else if (retire_ok && (tail_reg == PTR_W'(gi))) begin
          mem[gi] <= retire_tag_i;
        end
      end
    end
  endgenerate

  assign fl_tag_o      = mem[head_reg];
  assign fl_cur_head_o = head_reg;
  assign fl_empty_o    = empty;
  assign fl_err_o      = err_reg;

endmodule
